_rr_reg_arbiter: RTL and testbench



---
 rtl/_rr_reg_arbiter_pkg.sv | 19 +
 rtl/_rr_reg_arbiter_register_r_sync.sv | 25 ++
 rtl/_rr_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb__rr_reg_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/_rr_reg_arbiter_pkg.sv
// Shared constants for the register-bank write arbiter: FSM state encoding
// and default bank geometry.
package _rr_reg_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        ACK   = ST_ACK
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/_rr_reg_arbiter_register_r_sync.sv
// One bank entry: WIDTH-bit register with synchronous active-high reset
// and write enable.
module _register_r_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else if (we) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/_rr_reg_arbiter.sv
// N_REQ-way write arbiter owning a register bank with a combinational read port.
// Define ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module _rr_reg_arbiter
    import _rr_reg_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  wr_addr,
    input  logic [N_REQ*DATA_W-1:0]  wr_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic [PTR_W-1:0]   win_idx;
    logic               commit;
    logic [ADDR_W-1:0]  bank_addr;
    logic [DATA_W-1:0]  bank_din;
    logic [DATA_W-1:0]  bank_q [DEPTH];

    // The write lands on the GRANT->ACK edge only if the owner still requests.
    assign commit    = (state_reg == GRANT) && req[owner_reg];
    assign bank_addr = wr_addr[owner_reg*ADDR_W +: ADDR_W];
    assign bank_din  = wr_data[owner_reg*DATA_W +: DATA_W];

`ifdef ROUND_ROBIN_EN
    localparam int PW1 = PTR_W + 1;
    localparam logic [PTR_W:0] N_REQ_X = PW1'(N_REQ);

    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W:0]   cand;

    // Scan from the far end back toward the pointer so the closest requester wins.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + PW1'(k);
            if (cand >= N_REQ_X) begin
                cand = cand - N_REQ_X;
            end
            if (req[cand[PTR_W-1:0]]) begin
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (commit) begin
            ptr_next = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_idx = PTR_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        gnt_next   = '0;
        ack_next   = '0;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    owner_next = win_idx;
                    gnt_next   = N_REQ'(1) << win_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (commit) begin
                    ack_next   = N_REQ'(1) << owner_reg;
                    state_next = ACK;
                end else begin
                    state_next = IDLE;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ack_reg   <= ack_next;
            owner_reg <= owner_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
        _register_r_sync #(
            .WIDTH(DATA_W)
        ) u_entry (
            .clk   (clk),
            .reset (reset),
            .we    (commit && (bank_addr == ADDR_W'(gi))),
            .d     (bank_din),
            .q     (bank_q[gi])
        );
    end

    assign gnt     = gnt_reg;
    assign ack     = ack_reg;
    assign rd_data = bank_q[rd_addr];

endmodule

// File: tb/tb__rr_reg_arbiter.sv
// Randomized, self-checking bench for _rr_reg_arbiter against a transaction-level model,
// plus directed cases with literal expectations.
module tb__rr_reg_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int WA = N * AW;
    localparam int WD = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [WA-1:0] wr_addr;
    logic [WD-1:0] wr_data;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    _rr_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .ack     (ack),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Winner by the arbitration rule, stated directly.
    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    // Model: a transaction is "owned" by one requester and passes through
    // granted (1) and acked (2) phases; phase 0 means no transaction.
    int            m_phase = 0;
    int            m_owner = 0;
    int            m_ptr   = 0;
    logic [DW-1:0] m_bank [1<<AW];

    initial begin
        for (int a = 0; a < (1 << AW); a++) m_bank[a] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0;
                m_owner = 0;
                m_ptr   = 0;
                for (int a = 0; a < (1 << AW); a++) m_bank[a] = '0;
            end else if (m_phase == 0) begin
                if (req != '0) begin
                    m_owner = pick(req, m_ptr);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (req[m_owner]) begin
                    m_bank[wr_addr[m_owner*AW +: AW]] = wr_data[m_owner*DW +: DW];
                    $display("txn: requester %0d wrote %02h to addr %0d at %0t", m_owner,
                             wr_data[m_owner*DW +: DW], wr_addr[m_owner*AW +: AW], $time);
                    m_ptr   = (m_owner + 1) % N;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_phase = 0;
            end
            #1;
            check("gnt", 32'(gnt), (m_phase == 1) ? 32'(1 << m_owner) : 32'd0);
            check("ack", 32'(ack), (m_phase == 2) ? 32'(1 << m_owner) : 32'd0);
            check("rd_data", 32'(rd_data), 32'(m_bank[rd_addr]));
            check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            check("ack_onehot", 32'($onehot0(ack)), 32'd1);
            check("gnt_ack_overlap", 32'(gnt & ack), 32'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Full write by requester i starting from IDLE; returns in the following IDLE cycle.
    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        req[i] = 1'b1;
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
        @(negedge clk);
        @(negedge clk);
        req[i] = 1'b0;
        @(negedge clk);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    int ack_idx [5];
    int ack_cyc [5];
    int n_acks;

    initial begin
        reset   = 1'b1;
        req     = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and empty bank
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            #1;
            check("rst_rd_data", 32'(rd_data), 32'd0);
            @(negedge clk);
        end

        // Single write: requester 2, addr 5, data A5
        req = 4'b0100;
        wr_addr[2*AW +: AW] = 3'd5;
        wr_data[2*DW +: DW] = 8'hA5;
        rd_addr = 3'd5;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_no_ack", 32'(ack), 32'h0);
        @(negedge clk);
        check("single_ack", 32'(ack), 32'h4);
        check("single_gnt_clear", 32'(gnt), 32'h0);
        check("single_rd", 32'(rd_data), 32'hA5);
        req = '0;
        @(negedge clk);
        check("single_ack_pulse", 32'(ack), 32'h0);

        // Reset during GRANT: no write, bank cleared
        req = 4'b0100;
        wr_addr[2*AW +: AW] = 3'd1;
        wr_data[2*DW +: DW] = 8'h77;
        rd_addr = 3'd1;
        @(negedge clk);
        check("rstg_gnt", 32'(gnt), 32'h4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        check("rstg_gnt_clr", 32'(gnt), 32'h0);
        check("rstg_ack_clr", 32'(ack), 32'h0);
        check("rstg_no_write", 32'(rd_data), 32'h0);
        rd_addr = 3'd5;
        #1;
        check("rstg_bank_clr", 32'(rd_data), 32'h0);

        // Contention: everyone requests, each drops only in its ack cycle
        do_reset();
        n_acks = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ack != '0 && n_acks < 5) begin
                ack_idx[n_acks] = idx_of(ack);
                ack_cyc[n_acks] = c;
                n_acks++;
            end
            req = ~ack;
        end
        check("cont_count", 32'(n_acks), 32'd5);
        for (int t = 0; t < 5; t++) begin
`ifdef ROUND_ROBIN_EN
            check("cont_order", 32'(ack_idx[t]), 32'(t % 4));
`else
            check("cont_order", 32'(ack_idx[t]), 32'd0);
`endif
            if (t > 0) check("cont_spacing", 32'(ack_cyc[t] - ack_cyc[t-1]), 32'd3);
        end

        // Abort: requester 1 drops req while granted
        do_reset();
        rd_addr = 3'd2;
        do_write(0, 3'd2, 8'h3C);
        check("abort_pre", 32'(rd_data), 32'h3C);
        req = 4'b0010;
        wr_addr[1*AW +: AW] = 3'd2;
        wr_data[1*DW +: DW] = 8'hFF;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'h2);
        req = '0;
        @(negedge clk);
        check("abort_no_ack", 32'(ack), 32'h0);
        check("abort_no_gnt", 32'(gnt), 32'h0);
        check("abort_bank_kept", 32'(rd_data), 32'h3C);
        req = 4'b0011;
        @(negedge clk);
`ifdef ROUND_ROBIN_EN
        check("abort_ptr_kept", 32'(gnt), 32'h2);
`else
        check("abort_ptr_kept", 32'(gnt), 32'h1);
`endif
        req = '0;
        repeat (2) @(negedge clk);

        // Wrap-around: pointer at 3 after requester 2 completes
        do_reset();
        do_write(2, 3'd4, 8'h5A);
        req = 4'b0001;
        wr_addr[0 +: AW] = 3'd6;
        wr_data[0 +: DW] = 8'hC3;
        @(negedge clk);
        check("wrap_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        check("wrap_ack", 32'(ack), 32'h1);
        req = '0;
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
`ifdef ROUND_ROBIN_EN
        check("wrap_ptr", 32'(gnt), 32'h2);
`else
        check("wrap_ptr", 32'(gnt), 32'h1);
`endif
        req = '0;
        repeat (2) @(negedge clk);

        // Randomized traffic, checked every cycle by the model process
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
            end
            wr_addr = WA'($urandom);
            wr_data = WD'($urandom);
            rd_addr = AW'($urandom);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
